// File: rtl/link_controller_if.sv
// Bundle of requester, transceiver and receive-consumer signals around the link controller.
// The controller takes the slave view; the surrounding logic takes the master view.
interface link_controller_if #(
    parameter int PACKET_SIZE = 8
);
    logic                   req0_valid;
    logic [PACKET_SIZE-1:0] req0_data;
    logic                   req0_ready;
    logic                   req1_valid;
    logic [PACKET_SIZE-1:0] req1_data;
    logic                   req1_ready;
    logic                   tx_enable;
    logic [PACKET_SIZE-1:0] tx_data;
    logic                   irq_tx;
    logic                   irq_rx;
    logic [PACKET_SIZE-1:0] rx_packet;
    logic                   rx_valid;
    logic [PACKET_SIZE-1:0] rx_data;
    logic                   rx_ready;
    logic                   tx_grant;
    logic                   tx_timeout;
    logic                   rx_overflow;
    logic                   clear_overflow;
    logic                   busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  irq_tx, irq_rx, rx_packet, rx_ready, clear_overflow,
        output req0_ready, req1_ready, tx_enable, tx_data,
        output rx_valid, rx_data, tx_grant, tx_timeout, rx_overflow, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        output irq_tx, irq_rx, rx_packet, rx_ready, clear_overflow,
        input  req0_ready, req1_ready, tx_enable, tx_data,
        input  rx_valid, rx_data, tx_grant, tx_timeout, rx_overflow, busy
    );
endinterface

// File: rtl/link_controller.sv
// Link controller: round-robin arbitration of two transmit requesters, send/wait/gap
// sequencing of the transceiver, and a 2-entry show-ahead receive FIFO.
module link_controller #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int PACKET_SIZE    = 8
) (
    input logic              clock,
    input logic              reset,
    link_controller_if.slave bus
);
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W   = (GAP_EFF < 2) ? 1 : $clog2(GAP_EFF);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t                 r_state, w_state_next;
    logic [TMR_W-1:0]       r_timer, w_timer_next, w_timer_inc;
    logic [GAP_W-1:0]       r_gap, w_gap_next;
    logic                   r_tx_timeout, w_tx_timeout_next;
    logic [PACKET_SIZE-1:0] r_tx_data;
    logic                   r_tx_grant;
    logic                   w_sel, w_req_any, w_handshake;

    // Arbiter: on a tie the requester that did not win last time goes next.
    always_comb begin
        w_sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_sel = ~r_tx_grant;
        end else if (bus.req0_valid) begin
            w_sel = 1'b0;
        end else begin
            w_sel = 1'b1;
        end
    end

    assign w_req_any      = bus.req0_valid | bus.req1_valid;
    assign w_handshake    = (r_state == S_IDLE) && w_req_any;
    assign bus.req0_ready = (r_state == S_IDLE) && bus.req0_valid && !w_sel;
    assign bus.req1_ready = (r_state == S_IDLE) && bus.req1_valid && w_sel;
    assign w_timer_inc    = r_timer + TMR_W'(1);

    // TX next-state logic; irq_tx is only looked at while waiting.
    always_comb begin
        w_state_next      = r_state;
        w_timer_next      = r_timer;
        w_gap_next        = r_gap;
        w_tx_timeout_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) begin
                    w_state_next = S_SEND;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SEND: begin
                w_timer_next = '0;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.irq_tx) begin
                    w_state_next = S_GAP;
                    w_gap_next   = '0;
                end else if (w_timer_inc == TMR_LAST) begin
                    w_state_next      = S_GAP;
                    w_gap_next        = '0;
                    w_tx_timeout_next = 1'b1;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_next = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // TX state, timers and the latched packet/grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_gap        <= '0;
            r_tx_timeout <= 1'b0;
            r_tx_data    <= '0;
            r_tx_grant   <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_gap        <= w_gap_next;
            r_tx_timeout <= w_tx_timeout_next;
            if (w_handshake) begin
                r_tx_data  <= w_sel ? bus.req1_data : bus.req0_data;
                r_tx_grant <= w_sel;
            end
        end
    end

    assign bus.tx_enable  = (r_state == S_SEND);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.tx_timeout = r_tx_timeout;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_grant   = r_tx_grant;

    logic [PACKET_SIZE-1:0] r_mem [2];
    logic                   r_rd_ptr, r_wr_ptr, r_overflow;
    logic [1:0]             r_count;
    logic                   w_pop, w_full, w_push, w_drop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = (r_count != 2'd0) && bus.rx_ready;
    assign w_full = (r_count == 2'd2);
    assign w_push = bus.irq_rx && (!w_full || w_pop);
    assign w_drop = bus.irq_rx && w_full && !w_pop;

    // Receive FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.rx_packet;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.rx_valid    = (r_count != 2'd0);
    assign bus.rx_data     = r_mem[r_rd_ptr];
    assign bus.rx_overflow = r_overflow;
endmodule

// File: doc/link_controller.md
# link_controller

Sequences the optical transceiver's transmit and receive sides for the rest of the design. Two transmit requesters share the single encoder through a round-robin arbiter. The controller issues the `tx_enable` pulse, waits for `irq_tx` (or a timeout), and enforces an inter-packet guard gap. Received packets flagged by `irq_rx` are buffered in a 2-entry show-ahead FIFO with a valid/ready consumer port.

## Interface
- `GAP_CYCLES`, 16: idle guard cycles after each transmission (0 behaves as 1).
- `TIMEOUT_CYCLES`, 4096: maximum cycles spent waiting for `irq_tx`, ≥2; the counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide.
- `clock`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge of `clock`.
- `req0_valid` / `req1_valid`  in  1  requester has a packet to send.
- `req0_data` / `req1_data`  in  `PACKET_SIZE`  packet to send.
- `req0_ready` / `req1_ready`  out  1  packet accepted when ready && valid.
- `tx_enable`  out  1  one-cycle start pulse to the transceiver.
- `tx_data`  out  `PACKET_SIZE`  packet driven to the transceiver's `data_in`.
- `irq_tx`  in  1  transceiver packet-sent indication.
- `irq_rx`  in  1  transceiver packet-received pulse.
- `rx_packet`  in  `PACKET_SIZE`  transceiver `data_out`.
- `rx_valid`  out  1  FIFO head is valid.
- `rx_data`  out  `PACKET_SIZE`  FIFO head.
- `rx_ready`  in  1  consumer pops the head when rx_valid && rx_ready.
- `tx_grant`  out  1  index of the last accepted requester.
- `tx_timeout`  out  1  one-cycle pulse when a send times out.
- `rx_overflow`  out  1  sticky flag: a received packet was dropped.
- `clear_overflow`  in  1  clears `rx_overflow`.
- `busy`  out  1  TX FSM is not in IDLE.

## Operation
- TX FSM states: IDLE, SEND, WAIT, GAP.
- **IDLE**
  - Arbiter selects one valid requester.
  - When both are valid, the requester not equal to `tx_grant` wins.
  - `reqN_ready` is combinational: (state==IDLE) && (selected==N). At most one ready is high.
  - On handshake: latch data into `tx_data`, set `tx_grant`=N, go to SEND.
- **SEND**: `tx_enable`=1 for exactly this cycle, then go to WAIT. Clear the timer.
- **WAIT**
  - Timer increments each cycle.
  - `irq_tx` high → GAP.
  - Otherwise, timer reaching TIMEOUT_CYCLES-1 → pulse `tx_timeout` and go to GAP.
  - `irq_tx` on the timeout cycle counts as success: no timeout pulse.
- **GAP**: count max(GAP_CYCLES,1) cycles, then go to IDLE.
- `irq_tx` outside WAIT is ignored.
- `tx_data` holds its value from the handshake until the next handshake.
- **RX FIFO** (depth 2, independent of the TX FSM)
  - Each cycle with `irq_rx`=1 pushes `rx_packet`.
  - When full, a push with a simultaneous pop is accepted.
  - When full, a push without a pop is dropped, the contents are unchanged, and `rx_overflow` is set.
  - `clear_overflow` and a new overflow in the same cycle leave the flag set.
- **Reset**
  - All outputs go to 0; `tx_data`=0; FIFO empty; `tx_grant`=1, so req0 wins the first tie.
  - Reset mid-WAIT aborts the send with no `tx_timeout` pulse.

## Timing
- Handshake at cycle T → `tx_enable` at T+1 → WAIT from T+2.
- `irq_tx` first seen at cycle W (in WAIT) → GAP from W+1 → IDLE, and ready available, at W+1+max(GAP_CYCLES,1).
- Timeout: no `irq_tx` → `tx_timeout` at T+1+TIMEOUT_CYCLES.
- `busy` is high from T+1 through the last GAP cycle.
- RX latency: `irq_rx` at cycle R → `rx_valid`/`rx_data` at R+1. Pop at cycle P → next entry visible at P+1.
- Overflow set: `rx_overflow` goes high one cycle after the dropped push.

## Test plan
Configuration for all scenarios: GAP_CYCLES=4, TIMEOUT_CYCLES=20, `PACKET_SIZE`=8.

1. **Single send.** req0_valid with data 0xA5 at cycle 0, `irq_tx` at cycle 7 → `req0_ready` at 0; `tx_enable` only at 1; `tx_data`=0xA5; `busy` 1–11; `req0_ready` again possible at 12.
2. **Round-robin.** Both requesters permanently valid (0x11 / 0x22), `irq_tx` 3 cycles after each `tx_enable` → grants alternate 0,1,0,1; the first grant goes to req0; `tx_data` sequence 0x11, 0x22, 0x11.
3. **Timeout.** Send 0x3C with `irq_tx` never asserted → one `tx_timeout` pulse at cycle 21; IDLE at cycle 25; a late `irq_tx` at cycle 22 has no effect.
4. **RX overflow.** `irq_rx` with 0x01, 0x02, 0x03 on consecutive cycles, `rx_ready`=0 → `rx_data`=0x01; `rx_overflow` set; pops then yield 0x01, 0x02 and leave the FIFO empty. `clear_overflow` then clears the flag.
5. **Full-FIFO push with pop.** FIFO holds 0x01, 0x02; `irq_rx` 0x03 in the same cycle as `rx_ready`=1 → no overflow; subsequent pops yield 0x02, 0x03.
6. **Reset mid-WAIT.** `reset` asserted in cycle 4 of a send → next cycle all outputs 0; no `tx_timeout`; a fresh req1 transfer then succeeds, with `tx_grant`=1.
